network_interface_bridge: RTL and testbench

NETWORK_INTERFACE_BRIDGE -- requirements
Module: network_interface_bridge

---
 rtl/network_interface_bridge.sv | 157 +++++++++++++++
 tb/tb_network_interface_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_interface_bridge.sv
// Network interface bridge: filtered router->PE ingress FIFO and source-stamping
// PE->router egress FIFO, both first-word-fall-through and fully independent.

package nib_pkg;
  function automatic int isqrt(input int n);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  function automatic int seq_width(input int network_size);
    return $clog2(isqrt(network_size) * 2);
  endfunction
endpackage

// Synchronous FIFO with wrapping pointers and an occupancy counter; head is
// visible combinationally so the consumer sees data one cycle after a push.
module nib_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module network_interface_bridge #(
  parameter int          NETWORK_SIZE  = 256,
  parameter int unsigned LOCAL_ADDRESS = 8'b00000000,
  parameter int          FIFO_DEPTH    = 4,
  localparam int         ADDR_W        = $clog2(NETWORK_SIZE),
  localparam int         SEQ_W         = nib_pkg::seq_width(NETWORK_SIZE),
  localparam int         PACKET_SIZE   = 3 + SEQ_W + 2 * ADDR_W + 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   R_NI_valid,
  input  logic [PACKET_SIZE-1:0] R_NI_packet,
  output logic                   R_NI_ready,
  output logic                   NI_PE_valid,
  output logic [PACKET_SIZE-1:0] NI_PE_packet,
  input  logic                   NI_PE_ready,
  input  logic                   PE_NI_valid,
  input  logic [PACKET_SIZE-1:0] PE_NI_packet,
  output logic                   PE_NI_ready,
  output logic                   NI_R_valid,
  output logic [PACKET_SIZE-1:0] NI_R_packet,
  input  logic                   NI_R_ready,
  output logic [7:0]             drop_count
);
  // Handshake: a packet moves only on a rising edge where valid && ready; ready
  // never looks at valid, and a producer may hold or change an unaccepted packet.

  localparam int SRC_LSB = 32;
  localparam int DST_LSB = 32 + ADDR_W;
  localparam logic [ADDR_W-1:0] LOCAL = ADDR_W'(LOCAL_ADDRESS);

  logic                   in_full, in_empty;
  logic                   eg_full, eg_empty;
  logic                   in_xfer, in_accept;
  logic                   eg_xfer;
  logic [ADDR_W-1:0]      in_dest;
  logic [2:0]             in_type;
  logic [PACKET_SIZE-1:0] eg_data;

  assign in_dest   = R_NI_packet[DST_LSB +: ADDR_W];
  assign in_type   = R_NI_packet[PACKET_SIZE-1 -: 3];
  assign in_accept = (in_dest == LOCAL) || (in_type == 3'b111);

  // Ready is forced low during reset so nothing is taken while state clears.
  assign R_NI_ready = !in_full && !rst;
  assign PE_NI_ready = !eg_full && !rst;
  assign in_xfer = R_NI_valid && R_NI_ready;
  assign eg_xfer = PE_NI_valid && PE_NI_ready;

  assign NI_PE_valid = !in_empty;
  assign NI_R_valid  = !eg_empty;

  always_comb begin
    eg_data = PE_NI_packet;
    eg_data[SRC_LSB +: ADDR_W] = LOCAL;
  end

  nib_fifo #(.W(PACKET_SIZE), .DEPTH(FIFO_DEPTH)) u_ingress (
    .clk       (clk),
    .rst       (rst),
    .push      (in_xfer && in_accept),
    .push_data (R_NI_packet),
    .pop       (NI_PE_ready),
    .full      (in_full),
    .empty     (in_empty),
    .head      (NI_PE_packet)
  );

  nib_fifo #(.W(PACKET_SIZE), .DEPTH(FIFO_DEPTH)) u_egress (
    .clk       (clk),
    .rst       (rst),
    .push      (eg_xfer),
    .push_data (eg_data),
    .pop       (NI_R_ready),
    .full      (eg_full),
    .empty     (eg_empty),
    .head      (NI_R_packet)
  );

  // Filtered packets are still consumed; only the counter records them.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (in_xfer && !in_accept && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_network_interface_bridge.sv
// Bench for network_interface_bridge at default parameters: directed scenarios
// plus randomized two-path traffic checked against a queue-based model.

module tb_network_interface_bridge;
  localparam int PS = 56;

  logic          clk = 1'b0;
  logic          rst;
  logic          R_NI_valid;
  logic [PS-1:0] R_NI_packet;
  logic          R_NI_ready;
  logic          NI_PE_valid;
  logic [PS-1:0] NI_PE_packet;
  logic          NI_PE_ready;
  logic          PE_NI_valid;
  logic [PS-1:0] PE_NI_packet;
  logic          PE_NI_ready;
  logic          NI_R_valid;
  logic [PS-1:0] NI_R_packet;
  logic          NI_R_ready;
  logic [7:0]    drop_count;

  int checks = 0;
  int passes = 0;
  int exp_drops = 0;

  logic [PS-1:0] exp_q[$];
  logic [PS-1:0] eg_q[$];

  network_interface_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .R_NI_valid   (R_NI_valid),
    .R_NI_packet  (R_NI_packet),
    .R_NI_ready   (R_NI_ready),
    .NI_PE_valid  (NI_PE_valid),
    .NI_PE_packet (NI_PE_packet),
    .NI_PE_ready  (NI_PE_ready),
    .PE_NI_valid  (PE_NI_valid),
    .PE_NI_packet (PE_NI_packet),
    .PE_NI_ready  (PE_NI_ready),
    .NI_R_valid   (NI_R_valid),
    .NI_R_packet  (NI_R_packet),
    .NI_R_ready   (NI_R_ready),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [PS-1:0] make_pkt(input logic [2:0] t, input logic [4:0] s,
                                              input logic [7:0] d, input logic [7:0] src,
                                              input logic [31:0] p);
    return {t, s, d, src, p};
  endfunction

  function automatic logic [PS-1:0] rand_pkt(input logic [2:0] t, input logic [7:0] d);
    return make_pkt(t, 5'($urandom_range(0, 31)), d, 8'($urandom_range(0, 255)), $urandom);
  endfunction

  function automatic logic [PS-1:0] stamp_src(input logic [PS-1:0] p);
    logic [PS-1:0] r;
    r = p;
    r[39:32] = 8'h00;
    return r;
  endfunction

  function automatic bit is_local(input logic [PS-1:0] p);
    return (p[47:40] == 8'h00) || (p[55:53] == 3'b111);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    R_NI_valid = 1'b0; R_NI_packet = '0; NI_PE_ready = 1'b0;
    PE_NI_valid = 1'b0; PE_NI_packet = '0; NI_R_ready = 1'b0;
    step(); step();
    checks++; if (R_NI_ready !== 1'b0) $display("FAIL reset_r_ready: got %b want 0", R_NI_ready); else passes++;
    checks++; if (PE_NI_ready !== 1'b0) $display("FAIL reset_pe_ready: got %b want 0", PE_NI_ready); else passes++;
    checks++; if (NI_PE_valid !== 1'b0) $display("FAIL reset_pe_valid: got %b want 0", NI_PE_valid); else passes++;
    checks++; if (NI_R_valid !== 1'b0) $display("FAIL reset_r_valid: got %b want 0", NI_R_valid); else passes++;
    checks++; if (drop_count !== 8'd0) $display("FAIL reset_drops: got %0d want 0", drop_count); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (R_NI_ready !== 1'b1) $display("FAIL reset_release_r_ready: got %b want 1", R_NI_ready); else passes++;
    checks++; if (PE_NI_ready !== 1'b1) $display("FAIL reset_release_pe_ready: got %b want 1", PE_NI_ready); else passes++;
    exp_drops = 0;
  endtask

  task automatic test_basic_delivery();
    logic [PS-1:0] p;
    p = make_pkt(3'd0, 5'd3, 8'h00, 8'h42, 32'hDEADBEEF);
    NI_PE_ready = 1'b1;
    R_NI_valid = 1'b1; R_NI_packet = p;
    checks++; if (NI_PE_valid !== 1'b0) $display("FAIL basic_pre_valid: got %b want 0", NI_PE_valid); else passes++;
    step();
    R_NI_valid = 1'b0;
    checks++; if (NI_PE_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", NI_PE_valid); else passes++;
    checks++; if (NI_PE_packet !== p) $display("FAIL basic_packet: got %h want %h", NI_PE_packet, p); else passes++;
    step();
    checks++; if (NI_PE_valid !== 1'b0) $display("FAIL basic_drained: got %b want 0", NI_PE_valid); else passes++;
  endtask

  task automatic test_filter();
    logic [PS-1:0] p;
    NI_PE_ready = 1'b0;
    R_NI_valid = 1'b1; R_NI_packet = make_pkt(3'd0, 5'd1, 8'h05, 8'h11, $urandom);
    step();
    exp_drops++;
    R_NI_valid = 1'b0;
    checks++; if (R_NI_ready !== 1'b1) $display("FAIL filter_ready: got %b want 1", R_NI_ready); else passes++;
    checks++; if (NI_PE_valid !== 1'b0) $display("FAIL filter_valid: got %b want 0", NI_PE_valid); else passes++;
    checks++; if (drop_count !== 8'(exp_drops)) $display("FAIL filter_drops: got %0d want %0d", drop_count, exp_drops); else passes++;
    p = make_pkt(3'b111, 5'd2, 8'h05, 8'h11, $urandom);
    R_NI_valid = 1'b1; R_NI_packet = p;
    step();
    R_NI_valid = 1'b0;
    checks++; if (NI_PE_valid !== 1'b1) $display("FAIL bcast_valid: got %b want 1", NI_PE_valid); else passes++;
    checks++; if (NI_PE_packet !== p) $display("FAIL bcast_packet: got %h want %h", NI_PE_packet, p); else passes++;
    checks++; if (drop_count !== 8'(exp_drops)) $display("FAIL bcast_drops: got %0d want %0d", drop_count, exp_drops); else passes++;
    NI_PE_ready = 1'b1;
    step();
    checks++; if (NI_PE_valid !== 1'b0) $display("FAIL bcast_drained: got %b want 0", NI_PE_valid); else passes++;
  endtask

  task automatic test_backpressure();
    logic [PS-1:0] p;
    exp_q.delete();
    NI_PE_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p = rand_pkt(3'($urandom_range(0, 6)), 8'h00);
      exp_q.push_back(p);
      R_NI_valid = 1'b1; R_NI_packet = p;
      step();
    end
    checks++; if (R_NI_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", R_NI_ready); else passes++;
    R_NI_packet = rand_pkt(3'd0, 8'h00);
    step(); step();
    checks++; if (R_NI_ready !== 1'b0) $display("FAIL bp_hold_ready: got %b want 0", R_NI_ready); else passes++;
    checks++; if (NI_PE_packet !== exp_q[0]) $display("FAIL bp_head_stable: got %h want %h", NI_PE_packet, exp_q[0]); else passes++;
    R_NI_valid = 1'b0;
    NI_PE_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p = exp_q.pop_front();
      checks++; if (NI_PE_valid !== 1'b1) $display("FAIL bp_drain_valid[%0d]: got %b want 1", i, NI_PE_valid); else passes++;
      checks++; if (NI_PE_packet !== p) $display("FAIL bp_drain_packet[%0d]: got %h want %h", i, NI_PE_packet, p); else passes++;
      step();
    end
    checks++; if (NI_PE_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", NI_PE_valid); else passes++;
  endtask

  task automatic test_egress_source();
    logic [PS-1:0] p, e;
    logic [31:0] pay;
    pay = $urandom;
    p = make_pkt(3'd2, 5'd7, 8'h10, 8'hAA, pay);
    e = make_pkt(3'd2, 5'd7, 8'h10, 8'h00, pay);
    NI_R_ready = 1'b1;
    PE_NI_valid = 1'b1; PE_NI_packet = p;
    checks++; if (NI_R_valid !== 1'b0) $display("FAIL egress_pre_valid: got %b want 0", NI_R_valid); else passes++;
    step();
    PE_NI_valid = 1'b0;
    checks++; if (NI_R_valid !== 1'b1) $display("FAIL egress_valid: got %b want 1", NI_R_valid); else passes++;
    checks++; if (NI_R_packet !== e) $display("FAIL egress_packet: got %h want %h", NI_R_packet, e); else passes++;
    step();
    checks++; if (NI_R_valid !== 1'b0) $display("FAIL egress_drained: got %b want 0", NI_R_valid); else passes++;
  endtask

  task automatic test_random_traffic();
    logic [PS-1:0] p;
    bit in_take, in_give, eg_take, eg_give;
    exp_q.delete();
    eg_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      R_NI_valid  = ($urandom_range(0, 3) != 0);
      R_NI_packet = rand_pkt(3'($urandom_range(0, 7)),
                             ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      NI_PE_ready = ($urandom_range(0, 2) != 0);
      PE_NI_valid = ($urandom_range(0, 1) != 0);
      PE_NI_packet = rand_pkt(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      NI_R_ready  = ($urandom_range(0, 3) == 0);
      checks++; if (NI_PE_valid !== (exp_q.size() != 0)) $display("FAIL rnd_pe_valid@%0d: got %b want %b", cyc, NI_PE_valid, exp_q.size() != 0); else passes++;
      if (exp_q.size() != 0) begin
        checks++; if (NI_PE_packet !== exp_q[0]) $display("FAIL rnd_pe_packet@%0d: got %h want %h", cyc, NI_PE_packet, exp_q[0]); else passes++;
      end
      checks++; if (NI_R_valid !== (eg_q.size() != 0)) $display("FAIL rnd_r_valid@%0d: got %b want %b", cyc, NI_R_valid, eg_q.size() != 0); else passes++;
      if (eg_q.size() != 0) begin
        checks++; if (NI_R_packet !== eg_q[0]) $display("FAIL rnd_r_packet@%0d: got %h want %h", cyc, NI_R_packet, eg_q[0]); else passes++;
      end
      checks++; if (R_NI_ready !== (exp_q.size() < 4)) $display("FAIL rnd_r_ready@%0d: got %b want %b", cyc, R_NI_ready, exp_q.size() < 4); else passes++;
      checks++; if (PE_NI_ready !== (eg_q.size() < 4)) $display("FAIL rnd_pe_ready@%0d: got %b want %b", cyc, PE_NI_ready, eg_q.size() < 4); else passes++;
      checks++; if (drop_count !== 8'(exp_drops)) $display("FAIL rnd_drops@%0d: got %0d want %0d", cyc, drop_count, exp_drops); else passes++;
      in_take = R_NI_valid && (exp_q.size() < 4);
      in_give = NI_PE_ready && (exp_q.size() != 0);
      eg_take = PE_NI_valid && (eg_q.size() < 4);
      eg_give = NI_R_ready && (eg_q.size() != 0);
      if (in_give) p = exp_q.pop_front();
      if (in_take) begin
        if (is_local(R_NI_packet)) exp_q.push_back(R_NI_packet);
        else if (exp_drops < 255) exp_drops++;
      end
      if (eg_give) p = eg_q.pop_front();
      if (eg_take) eg_q.push_back(stamp_src(PE_NI_packet));
      step();
    end
    R_NI_valid = 1'b0; PE_NI_valid = 1'b0;
    NI_PE_ready = 1'b1; NI_R_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    exp_q.delete();
    eg_q.delete();
    checks++; if (NI_PE_valid !== 1'b0 || NI_R_valid !== 1'b0) $display("FAIL rnd_final_empty: got %b%b want 00", NI_PE_valid, NI_R_valid); else passes++;
  endtask

  task automatic test_drop_saturation();
    NI_PE_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      R_NI_valid = 1'b1;
      R_NI_packet = rand_pkt(3'($urandom_range(0, 6)), 8'($urandom_range(1, 255)));
      step();
      if (exp_drops < 255) exp_drops++;
      if (i == 40) begin
        checks++; if (drop_count !== 8'(exp_drops)) $display("FAIL sat_mid: got %0d want %0d", drop_count, exp_drops); else passes++;
      end
    end
    R_NI_valid = 1'b0;
    checks++; if (drop_count !== 8'd255) $display("FAIL sat_final: got %0d want 255", drop_count); else passes++;
    checks++; if (NI_PE_valid !== 1'b0) $display("FAIL sat_no_delivery: got %b want 0", NI_PE_valid); else passes++;
    checks++; if (R_NI_ready !== 1'b1) $display("FAIL sat_ready: got %b want 1", R_NI_ready); else passes++;
  endtask

  task automatic test_reset_midop();
    NI_PE_ready = 1'b0; NI_R_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      R_NI_valid = 1'b1; R_NI_packet = rand_pkt(3'd1, 8'h00);
      PE_NI_valid = 1'b1; PE_NI_packet = rand_pkt(3'd1, 8'h33);
      step();
    end
    R_NI_valid = 1'b0; PE_NI_valid = 1'b0;
    checks++; if (NI_PE_valid !== 1'b1 || NI_R_valid !== 1'b1) $display("FAIL midrst_loaded: got %b%b want 11", NI_PE_valid, NI_R_valid); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (R_NI_ready !== 1'b0 || PE_NI_ready !== 1'b0) $display("FAIL midrst_ready_low: got %b%b want 00", R_NI_ready, PE_NI_ready); else passes++;
    step(); step();
    exp_drops = 0;
    checks++; if (NI_PE_valid !== 1'b0 || NI_R_valid !== 1'b0) $display("FAIL midrst_valid_low: got %b%b want 00", NI_PE_valid, NI_R_valid); else passes++;
    checks++; if (drop_count !== 8'd0) $display("FAIL midrst_drops: got %0d want 0", drop_count); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (R_NI_ready !== 1'b1 || PE_NI_ready !== 1'b1) $display("FAIL midrst_ready_high: got %b%b want 11", R_NI_ready, PE_NI_ready); else passes++;
    NI_PE_ready = 1'b1; NI_R_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (NI_PE_valid !== 1'b0 || NI_R_valid !== 1'b0) $display("FAIL midrst_stale[%0d]: got %b%b want 00", i, NI_PE_valid, NI_R_valid); else passes++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic_delivery();
    test_filter();
    test_backpressure();
    test_egress_source();
    test_random_traffic();
    test_drop_saturation();
    test_reset_midop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
